// File: rtl/rf_scoreboard.sv
// Parametrised register file with a per-register pending-write scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module rf_scoreboard #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REG   = 4,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 0,
  parameter int ADDR_W    = $clog2(NUM_REG)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_RD*ADDR_W-1:0]      rd_addr,
  output logic [NUM_RD*WORD_SIZE-1:0]   rd_data,
  output logic [NUM_RD-1:0]             rd_busy,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [WORD_SIZE-1:0]          wr_data,
  input  logic                          iss_en,
  input  logic [ADDR_W-1:0]             iss_addr,
  output logic                          iss_ready,
  output logic [$clog2(NUM_REG+1)-1:0]  pend_cnt
);

  localparam int CNT_W = $clog2(NUM_REG + 1);

  logic [WORD_SIZE-1:0] regs [NUM_REG];
  logic [NUM_REG-1:0]   busy;
  logic [NUM_REG-1:0]   busy_nxt;
  logic                 wr_ok;
  logic                 wr_clr;
  logic                 iss_zero;
  logic                 iss_acc;

  // With ZERO_REG, address 0 is inert: never written, never marked pending.
  assign wr_ok     = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  assign iss_zero  = (ZERO_REG != 0) && (iss_addr == '0);
  assign iss_ready = iss_zero || !busy[iss_addr] || (wr_en && (wr_addr == iss_addr));
  assign iss_acc   = iss_en && iss_ready && !iss_zero;
  // Only a write that retires a pending entry decrements the count.
  assign wr_clr    = wr_ok && busy[wr_addr];

  always_comb begin
    busy_nxt = busy;
    if (wr_ok)
      busy_nxt[wr_addr] = 1'b0;
    if (iss_acc)
      busy_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REG; i++)
        regs[i] <= '0;
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_ok)
        regs[wr_addr] <= wr_data;
      busy     <= busy_nxt;
      pend_cnt <= pend_cnt + CNT_W'(iss_acc) - CNT_W'(wr_clr);
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[g*ADDR_W +: ADDR_W];

    always_comb begin
      rd_data[g*WORD_SIZE +: WORD_SIZE] = regs[ra];
      rd_busy[g]                        = busy[ra];
`ifdef RF_BYPASS_EN
      if (reset_n && wr_en && (wr_addr == ra)) begin
        rd_data[g*WORD_SIZE +: WORD_SIZE] = wr_data;
        rd_busy[g]                        = 1'b0;
      end
`endif
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_data[g*WORD_SIZE +: WORD_SIZE] = '0;
        rd_busy[g]                        = 1'b0;
      end
    end
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Parametrised successor to the 4x16 two-read/one-write register file.
- Generalises word width, register count and read-port count.
- Adds a per-register scoreboard of pending-write (busy) bits with an issue/writeback handshake and a live pending-write counter.
- Sits between decode (issue, operand read) and writeback in the multi-cycle/pipelined CPU datapath.

Parameters:
- WORD_SIZE, 16, data width of each register.
- NUM_REG, 4, number of registers; must be a power of two and at least 2.
- NUM_RD, 2, number of combinational read ports, 1..4.
- ZERO_REG, 0, when 1 register 0 reads as constant 0 and is never written or marked busy.
- ADDR_W, $clog2(NUM_REG), derived address width; do not override.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses, flattened; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*WORD_SIZE  read data, flattened in the same order as rd_addr.
- rd_busy  out  NUM_RD  bit k = register addressed by read port k has a pending write.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  WORD_SIZE  writeback data.
- iss_en  in  1  issue request; marks iss_addr as pending.
- iss_addr  in  ADDR_W  issue destination.
- iss_ready  out  1  issue may be accepted this cycle.
- pend_cnt  out  $clog2(NUM_REG+1)  number of busy registers.

Behaviour:
- Reset (reset_n low, asynchronous): all registers = 0, all busy bits = 0, pend_cnt = 0.
  - While reset is held, rd_data reads 0 and rd_busy = 0.
  - Reset asserted mid-operation discards pending state immediately, with no clock required.
- Reads: combinational from register state; rd_data[k] = reg[rd_addr[k]]; rd_busy[k] = busy[rd_addr[k]]. Any ports may alias the same address.
- Write: at the rising clk edge with wr_en = 1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. Visible on reads the cycle after the edge (1-cycle latency). A write to a non-busy register is legal and simply updates data.
- Issue: iss_ready = !busy[iss_addr] | (wr_en & wr_addr == iss_addr). An issue is accepted at the edge when iss_en & iss_ready, and sets busy[iss_addr] <= 1.
- Simultaneous write and accepted issue to the same address: data is written, busy ends at 1 (the new pending write wins).
- Simultaneous write and issue to different addresses: both take effect.
- iss_en while iss_ready = 0: no state change. The requester must hold iss_en/iss_addr until it sees iss_ready.
- pend_cnt: registered popcount of busy, updated each edge by +1 / -1 / 0, or held when an issue and a write on the same address cancel. It never exceeds NUM_REG and never underflows, because a write to a non-busy register does not decrement it.
- ZERO_REG = 1:
  - Address 0 always reads 0, rd_busy = 0.
  - Writes to 0 are ignored.
  - Issue to 0 is always ready and does not set busy or change pend_cnt.
- Out-of-range addresses cannot occur (NUM_REG is a power of two).

Optional Feature:
- Macro RF_BYPASS_EN.
- When defined: a read port whose address equals wr_addr while wr_en = 1 returns wr_data combinationally in the same cycle and reports rd_busy = 0 for that port. ZERO_REG still forces address 0 to read 0.
- When undefined: reads return the pre-edge register value and the registered busy bit. The new data appears the cycle after the write.

Test Plan:
- Reset: write 16'h52df to r3, pulse reset_n low for 3 ns between edges -> all rd_data = 0, pend_cnt = 0 before the next edge.
- Write/read aliasing: write 16'h7953 to r1, then rd_addr = {1,1} -> both ports read 16'h7953 one cycle after the write edge. Under RF_BYPASS_EN they read it in the write cycle itself.
- Scoreboard: issue r2 -> next cycle rd_busy for r2 = 1, pend_cnt = 1, iss_ready = 0 for iss_addr = 2. Then write 16'hc6d6 to r2 -> busy cleared, pend_cnt = 0, data = 16'hc6d6.
- Same-cycle issue+write on r0 with ZERO_REG = 0 -> r0 = written data, busy[0] = 1, pend_cnt unchanged from before the edge.
- Fill: issue r0..r3 on consecutive cycles -> pend_cnt = 4. Write to non-busy r1 after it is cleared -> pend_cnt does not underflow.
- ZERO_REG = 1: write 16'hffff to r0 and issue r0 -> r0 reads 0, rd_busy = 0, pend_cnt = 0.
